// File: rtl/qkv_requant_packer_if.sv
// Bus bundle for qkv_requant_packer: start/status handshake plus the source (FP32, read-only)
// and destination (packed int8) single-port SRAM pins.
//   master : packer side (drives status and both SRAM control/address/data-out pins)
//   slave  : environment side (drives en/shift and the source read data)
interface qkv_requant_packer_if #(
  parameter int unsigned SRC_AW = 7,
  parameter int unsigned DST_AW = 5
) ();
  logic              en;
  logic [4:0]        shift;
  logic              busy;
  logic              finished;
  logic [127:0]      SRC_MEM_DOUT;
  logic              SRC_MEM_CEB;
  logic              SRC_MEM_WEN;
  logic [SRC_AW-1:0] SRC_MEM_ADDR;
  logic [127:0]      DST_MEM_DIN;
  logic              DST_MEM_CEB;
  logic              DST_MEM_WEN;
  logic [DST_AW-1:0] DST_MEM_ADDR;

  modport master (
    input  en, shift, SRC_MEM_DOUT,
    output busy, finished, SRC_MEM_CEB, SRC_MEM_WEN, SRC_MEM_ADDR,
           DST_MEM_DIN, DST_MEM_CEB, DST_MEM_WEN, DST_MEM_ADDR
  );

  modport slave (
    output en, shift, SRC_MEM_DOUT,
    input  busy, finished, SRC_MEM_CEB, SRC_MEM_WEN, SRC_MEM_ADDR,
           DST_MEM_DIN, DST_MEM_CEB, DST_MEM_WEN, DST_MEM_ADDR
  );
endinterface

// File: rtl/qkv_requant_packer.sv
// Reads SRC_WORDS FP32x4 words from the projection output SRAM, scales each lane by 2^shift,
// rounds half away from zero, saturates to [-127,127] and packs four source words (16 bytes)
// into each destination SRAM word.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus_io   : en/shift start request, busy/finished status, source and destination SRAM pins
module qkv_requant_packer #(
  parameter int unsigned SRC_WORDS = 128,
  parameter int unsigned SRC_AW    = 7,
  parameter int unsigned DST_AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  qkv_requant_packer_if.master  bus_io
);

  localparam logic [SRC_AW-1:0] SrcLast = SRC_AW'(SRC_WORDS - 1);
  localparam logic [DST_AW-1:0] DstLast = DST_AW'(SRC_WORDS / 4 - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [4:0]        shift_q, shift_d;
  logic              src_ceb_q, src_ceb_d;
  logic [SRC_AW-1:0] src_addr_q, src_addr_d;
  logic              rd_vld_q, rd_vld_d;   // SRC_MEM_DOUT holds the word read last cycle
  logic [SRC_AW-1:0] rd_idx_q, rd_idx_d;   // source index of that word
  logic [127:0]      pack_q, pack_d;
  logic              dst_ceb_q, dst_ceb_d; // also drives WEN: every access is a write
  logic [DST_AW-1:0] dst_addr_q, dst_addr_d;
  logic [127:0]      dst_din_q, dst_din_d;
  logic [31:0]       conv_word;

  // FP32 -> saturated int8 of value * 2^sh_exp.
  function automatic logic [7:0] to_int8(input logic [31:0] fp, input logic [4:0] sh_exp);
    logic              sgn;
    logic [7:0]        e;
    logic [22:0]       f;
    logic signed [9:0] e_unb;
    logic [4:0]        rs;
    logic [24:0]       sum;
    logic [24:0]       q;
    logic [7:0]        mag;
    sgn   = fp[31];
    e     = fp[30:23];
    f     = fp[22:0];
    e_unb = $signed({2'b00, e}) - 10'sd127 + 10'($signed(sh_exp));
    // Only meaningful for e_unb in -1..6, where the right shift is 17..24.
    rs    = 5'(10'sd23 - e_unb);
    sum   = {2'b01, f} + (25'd1 << (rs - 5'd1));
    q     = sum >> rs;
    if (e == 8'hFF)              mag = (f == '0) ? 8'd127 : 8'd0;
    else if (e == 8'h00)         mag = 8'd0;
    else if (e_unb >= 10'sd7)    mag = 8'd127;
    else if (e_unb <= -10'sd2)   mag = 8'd0;
    else if (q > 25'd127)        mag = 8'd127;
    else                         mag = q[7:0];
    return sgn ? (8'd0 - mag) : mag;
  endfunction

  always_comb begin
    conv_word = '0;
    for (int l = 0; l < 4; l++) begin
      conv_word[8*l +: 8] = to_int8(bus_io.SRC_MEM_DOUT[32*l +: 32], shift_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    src_ceb_d  = src_ceb_q;
    src_addr_d = src_addr_q;
    rd_vld_d   = ~src_ceb_q;
    rd_idx_d   = src_addr_q;
    pack_d     = pack_q;
    dst_ceb_d  = 1'b1;
    dst_addr_d = dst_addr_q;
    dst_din_d  = dst_din_q;

    if (rd_vld_q) begin
      pack_d[{rd_idx_q[1:0], 5'd0} +: 32] = conv_word;
      // Fourth slot landing: the packed word goes out next cycle.
      if (rd_idx_q[1:0] == 2'd3) begin
        dst_ceb_d  = 1'b0;
        dst_addr_d = DST_AW'(rd_idx_q >> 2);
        dst_din_d  = pack_d;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus_io.en) begin
          state_d    = StRead;
          shift_d    = bus_io.shift;
          src_ceb_d  = 1'b0;
          src_addr_d = '0;
        end
      end
      StRead: begin
        if (src_addr_q == SrcLast) begin
          src_ceb_d = 1'b1;
          state_d   = StDrain;
        end else begin
          src_addr_d = src_addr_q + 1'b1;
        end
      end
      StDrain: begin
        if (!dst_ceb_q && (dst_addr_q == DstLast)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      src_ceb_q  <= 1'b1;
      src_addr_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      pack_q     <= '0;
      dst_ceb_q  <= 1'b1;
      dst_addr_q <= '0;
      dst_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      src_ceb_q  <= src_ceb_d;
      src_addr_q <= src_addr_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      pack_q     <= pack_d;
      dst_ceb_q  <= dst_ceb_d;
      dst_addr_q <= dst_addr_d;
      dst_din_q  <= dst_din_d;
    end
  end

  assign bus_io.busy         = (state_q != StIdle);
  assign bus_io.finished     = (state_q == StDone);
  assign bus_io.SRC_MEM_CEB  = src_ceb_q;
  assign bus_io.SRC_MEM_WEN  = 1'b1;
  assign bus_io.SRC_MEM_ADDR = src_addr_q;
  assign bus_io.DST_MEM_DIN  = dst_din_q;
  assign bus_io.DST_MEM_CEB  = dst_ceb_q;
  assign bus_io.DST_MEM_WEN  = dst_ceb_q;
  assign bus_io.DST_MEM_ADDR = dst_addr_q;

endmodule

// File: tb/tb_qkv_requant_packer.sv
module tb_qkv_requant_packer;
  localparam int unsigned SrcWords = 128;
  localparam int unsigned DstWords = SrcWords / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qkv_requant_packer_if #(.SRC_AW(7), .DST_AW(5)) bus ();

  qkv_requant_packer #(
    .SRC_WORDS(SrcWords),
    .SRC_AW(7),
    .DST_AW(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  logic [127:0] src_mem [SrcWords];
  logic [127:0] dst_mem [DstWords];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int stray = 0;
  int mon_off;
  int rd_off[$];
  int rd_addr[$];
  int wr_off[$];
  int wr_addr[$];
  int wr_wen[$];
  int fin_log[$];
  int busy_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Source SRAM: 1-cycle read latency.
  always @(posedge clk) if (!bus.SRC_MEM_CEB) bus.SRC_MEM_DOUT <= src_mem[bus.SRC_MEM_ADDR];

  // Destination SRAM.
  always @(posedge clk)
    if (!bus.DST_MEM_CEB && !bus.DST_MEM_WEN) dst_mem[bus.DST_MEM_ADDR] <= bus.DST_MEM_DIN;

  // Event log, cycle offsets relative to the cycle en was sampled.
  always @(negedge clk) begin
    mon_off = cyc - t0;
    if (bus.busy) busy_log.push_back(mon_off);
    if (bus.finished) fin_log.push_back(mon_off);
    if (!bus.SRC_MEM_CEB) begin
      rd_off.push_back(mon_off);
      rd_addr.push_back(int'(bus.SRC_MEM_ADDR));
    end
    if (!bus.DST_MEM_CEB) begin
      wr_off.push_back(mon_off);
      wr_addr.push_back(int'(bus.DST_MEM_ADDR));
      wr_wen.push_back(int'(bus.DST_MEM_WEN));
    end
    if ((!bus.DST_MEM_WEN && bus.DST_MEM_CEB) || (bus.SRC_MEM_WEN !== 1'b1)) stray++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference conversion straight from the numeric rules, using real arithmetic.
  function automatic logic [7:0] ref_byte(input logic [31:0] w, input int sh);
    int  e;
    int  r;
    real mag;
    e = int'(w[30:23]);
    if (e == 255) return (w[22:0] != 0) ? 8'h00 : (w[31] ? 8'h81 : 8'h7F);
    if (e == 0) return 8'h00;
    mag = (1.0 + real'(w[22:0]) / 8388608.0) * (2.0 ** real'(e - 127 + sh));
    mag = $floor(mag + 0.5);
    if (mag > 127.0) r = 127;
    else r = int'(mag);
    return w[31] ? 8'(-r) : 8'(r);
  endfunction

  function automatic logic [127:0] exp_word(input int j, input int sh);
    logic [127:0] w;
    w = '0;
    for (int m = 0; m < 4; m++)
      for (int l = 0; l < 4; l++)
        w[8*(4*m+l) +: 8] = ref_byte(src_mem[4*j+m][32*l +: 32], sh);
    return w;
  endfunction

  function automatic logic [31:0] rand_fp();
    int unsigned mode;
    logic [31:0] w;
    mode     = $urandom_range(0, 9);
    w[31]    = 1'($urandom);
    w[22:0]  = 23'($urandom);
    w[30:23] = 8'($urandom_range(110, 140));
    case (mode)
      0: begin
        w[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) w[22:0] = '0;
      end
      1: w[30:23] = 8'h00;
      2: begin
        // Few fraction bits: lands on exact .5 ties after scaling.
        w[30:23] = 8'($urandom_range(125, 132));
        w[16:0]  = '0;
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic fill_random(input int from);
    for (int k = from; k < SrcWords; k++)
      src_mem[k] = {rand_fp(), rand_fp(), rand_fp(), rand_fp()};
  endtask

  task automatic clear_logs();
    rd_off.delete();
    rd_addr.delete();
    wr_off.delete();
    wr_addr.delete();
    wr_wen.delete();
    fin_log.delete();
    busy_log.delete();
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_busy"}, 128'(bus.busy), 128'(0));
    chk({pfx, "_finished"}, 128'(bus.finished), 128'(0));
    chk({pfx, "_src_ceb"}, 128'(bus.SRC_MEM_CEB), 128'(1));
    chk({pfx, "_src_wen"}, 128'(bus.SRC_MEM_WEN), 128'(1));
    chk({pfx, "_dst_ceb"}, 128'(bus.DST_MEM_CEB), 128'(1));
    chk({pfx, "_dst_wen"}, 128'(bus.DST_MEM_WEN), 128'(1));
    chk({pfx, "_src_addr"}, 128'(bus.SRC_MEM_ADDR), 128'(0));
    chk({pfx, "_dst_addr"}, 128'(bus.DST_MEM_ADDR), 128'(0));
    chk({pfx, "_dst_din"}, bus.DST_MEM_DIN, 128'(0));
  endtask

  // One complete run with source contents already in src_mem.
  task automatic run(input string name, input int sh, input bit pulse_busy, input int tail);
    int bad;
    bit seen;
    clear_logs();
    @(posedge clk); #1;
    bus.en = 1'b1;
    bus.shift = 5'(sh);
    t0 = cyc;
    @(posedge clk); #1;
    bus.en = 1'b0;
    bus.shift = 5'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      bus.en = pulse_busy && ((cyc - t0 == 20) || (cyc - t0 == 21) || (cyc - t0 == 130));
      if (bus.finished) seen = 1'b1;
    end
    #1;
    bus.en = 1'b0;
    chk_i({name, "_finish_seen"}, int'(seen), 1);
    repeat (tail) @(negedge clk);
    if (tail > 0) #1;

    chk_i({name, "_rd_count"}, rd_off.size(), SrcWords);
    bad = 0;
    foreach (rd_off[k]) if (rd_off[k] != k + 1 || rd_addr[k] != k) bad++;
    chk_i({name, "_rd_seq"}, bad, 0);
    chk_i({name, "_wr_count"}, wr_off.size(), DstWords);
    bad = 0;
    foreach (wr_off[j]) if (wr_off[j] != 4*j + 6 || wr_addr[j] != j || wr_wen[j] != 0) bad++;
    chk_i({name, "_wr_seq"}, bad, 0);
    chk_i({name, "_fin_count"}, fin_log.size(), 1);
    chk_i({name, "_fin_cycle"}, (fin_log.size() > 0) ? fin_log[0] : -1, SrcWords + 3);
    chk_i({name, "_busy_count"}, busy_log.size(), SrcWords + 3);
    chk_i({name, "_busy_first"}, (busy_log.size() > 0) ? busy_log[0] : -1, 1);
    chk_i({name, "_busy_last"}, (busy_log.size() > 0) ? busy_log[$] : -1, SrcWords + 3);
    for (int j = 0; j < DstWords; j++)
      chk($sformatf("%s_dst%0d", name, j), dst_mem[j], exp_word(j, sh));
    chk_i({name, "_stray"}, stray, 0);
  endtask

  initial begin
    int sh;
    bus.en = 1'b0;
    bus.shift = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic, saturation/specials and small values, with en pulses while busy.
    src_mem[0] = 128'h40200000_BF000000_3FC00000_3F800000;
    src_mem[1] = 128'h7FC00000_7F800000_C47A0000_43480000;
    src_mem[2] = 128'h00000000_00000000_00000001_3EFAE148;
    src_mem[3] = '0;
    fill_random(4);
    run("basic", 0, 1'b1, 2);
    chk("basic_bytes", 128'(dst_mem[0][31:0]), 128'(32'h03FF0201));
    chk("special_bytes", 128'(dst_mem[0][63:32]), 128'(32'h007F817F));
    chk("small_bytes", 128'(dst_mem[0][79:64]), 128'(16'h0000));
    chk("zero_word_bytes", 128'(dst_mem[0][127:96]), 128'(32'h0));

    // Positive shift, then a run started on the cycle right after finished.
    src_mem[0] = 128'h00000000_00000000_C0533333_3FA00000;
    fill_random(1);
    run("scale_p2", 2, 1'b0, 0);
    chk("scale_p2_bytes", 128'(dst_mem[0][15:0]), 128'(16'hF305));
    src_mem[0] = 128'h00000000_00000000_00000000_41400000;
    fill_random(1);
    run("scale_m3", -3, 1'b0, 2);
    chk("scale_m3_bytes", 128'(dst_mem[0][31:0]), 128'(32'h00000002));

    // Random shifts.
    for (int r = 0; r < 3; r++) begin
      sh = $urandom_range(0, 31);
      sh = (sh > 15) ? sh - 32 : sh;
      fill_random(0);
      run($sformatf("rand%0d", r), sh, 1'b0, 2);
    end

    // Reset in cycle 50 of a run.
    fill_random(0);
    clear_logs();
    @(posedge clk); #1;
    bus.en = 1'b1;
    bus.shift = '0;
    t0 = cyc;
    @(posedge clk); #1;
    bus.en = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    chk_idle("midrst");
    repeat (79) @(negedge clk);
    #1;
    chk_i("midrst_no_reads", rd_off.size(), 0);
    chk_i("midrst_no_writes", wr_off.size(), 0);
    chk_i("midrst_no_finish", fin_log.size(), 0);
    chk_i("midrst_no_busy", busy_log.size(), 0);

    // Clean restart after the abort.
    sh = 1;
    fill_random(0);
    run("restart", sh, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
